// File: rtl/data_mem_arbiter_pkg.sv
// Shared encodings and default widths for the data memory arbiter.
package data_mem_arbiter_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   typedef enum logic {
      OWN_CORE = 1'b0,
      OWN_DBG  = 1'b1
   } owner_t;

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// Two-input round-robin grant: a lone requester always wins, and on a tie
// the requester that was not granted last time wins.
module rr_arbiter2
   import data_mem_arbiter_pkg::*;
(
   input  logic req_core,
   input  logic req_dbg,
   input  logic last_grant,
   output logic gnt_valid,
   output logic gnt_owner
);

   // Grant decode; gnt_owner is only meaningful while gnt_valid is high
   always_comb begin
      gnt_valid = req_core | req_dbg;
      gnt_owner = OWN_CORE;
      if (req_core && req_dbg) begin
         gnt_owner = (last_grant == OWN_CORE) ? OWN_DBG : OWN_CORE;
      end else if (req_dbg) begin
         gnt_owner = OWN_DBG;
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Serialises core and debug accesses onto the single-port data memory.
// One access takes IDLE -> ISSUE -> RESP; all memory-side outputs and acks
// are registered so they are stable for the whole cycle they are valid.
module data_mem_arbiter
   import data_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
)(
   input  logic              CLOCK,
   input  logic              peripheral_reset,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic              core_ack,
   output logic [DATA_W-1:0] core_rdata,
   output logic              core_stall,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_en,
   output logic              mem_rd_en,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   state_t              state, state_d;
   owner_t              last_grant;
   logic                gnt_valid;
   logic                gnt_owner;

   owner_t              req_owner;
   logic                req_we;
   logic [ADDR_W-1:0]   req_addr;
   logic [DATA_W-1:0]   req_wdata;

   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;

   logic                latch_en;
   logic                mem_en_d, mem_rd_en_d, mem_wr_en_d;
   logic [ADDR_W-1:0]   mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_d;
   logic                core_ack_d, dbg_ack_d;

   logic [DATA_W-1:0]   core_rdata_q, dbg_rdata_q;

   rr_arbiter2 u_rr (
      .req_core   (core_req),
      .req_dbg    (dbg_req),
      .last_grant (last_grant),
      .gnt_valid  (gnt_valid),
      .gnt_owner  (gnt_owner)
   );

   // Pick the winning requester's command fields
   always_comb begin
      sel_we    = core_we;
      sel_addr  = core_addr;
      sel_wdata = core_wdata;
      if (gnt_owner == OWN_DBG) begin
         sel_we    = dbg_we;
         sel_addr  = dbg_addr;
         sel_wdata = dbg_wdata;
      end
   end

   // Next state plus the values the registered outputs take next cycle
   always_comb begin
      state_d     = state;
      latch_en    = 1'b0;
      mem_en_d    = 1'b0;
      mem_rd_en_d = 1'b0;
      mem_wr_en_d = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      core_ack_d  = 1'b0;
      dbg_ack_d   = 1'b0;
      case (state)
         IDLE: begin
            if (gnt_valid) begin
               state_d     = ISSUE;
               latch_en    = 1'b1;
               mem_en_d    = 1'b1;
               mem_wr_en_d = sel_we;
               mem_rd_en_d = ~sel_we;
               mem_addr_d  = sel_addr;
               mem_wdata_d = sel_wdata;
            end
         end
         ISSUE: begin
            state_d    = RESP;
            core_ack_d = (req_owner == OWN_CORE);
            dbg_ack_d  = (req_owner == OWN_DBG);
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, round-robin history and registered memory/ack outputs
   always_ff @(posedge CLOCK) begin
      if (peripheral_reset) begin
         state      <= IDLE;
         last_grant <= OWN_DBG;
         mem_en     <= 1'b0;
         mem_rd_en  <= 1'b0;
         mem_wr_en  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         core_ack   <= 1'b0;
         dbg_ack    <= 1'b0;
      end else begin
         state      <= state_d;
         if (latch_en) begin
            last_grant <= owner_t'(gnt_owner);
         end
         mem_en     <= mem_en_d;
         mem_rd_en  <= mem_rd_en_d;
         mem_wr_en  <= mem_wr_en_d;
         mem_addr   <= mem_addr_d;
         mem_wdata  <= mem_wdata_d;
         core_ack   <= core_ack_d;
         dbg_ack    <= dbg_ack_d;
      end
   end

   // Request latch; only read while an access is in flight, so no reset
   always_ff @(posedge CLOCK) begin
      if (latch_en) begin
         req_owner <= owner_t'(gnt_owner);
         req_we    <= sel_we;
         req_addr  <= sel_addr;
         req_wdata <= sel_wdata;
      end
   end

   // Keep the last read word per requester so rdata holds between acks
   always_ff @(posedge CLOCK) begin
      if (peripheral_reset) begin
         core_rdata_q <= '0;
         dbg_rdata_q  <= '0;
      end else if (state == RESP && !req_we) begin
         if (req_owner == OWN_CORE) begin
            core_rdata_q <= mem_rdata;
         end else begin
            dbg_rdata_q  <= mem_rdata;
         end
      end
   end

   // The memory's registered read word arrives in RESP, the same cycle as
   // the ack, so it is forwarded during the ack and held afterwards.
   assign core_rdata = (core_ack && !req_we) ? mem_rdata : core_rdata_q;
   assign dbg_rdata  = (dbg_ack  && !req_we) ? mem_rdata : dbg_rdata_q;
   assign core_stall = core_req & ~core_ack;
   assign busy       = (state != IDLE);

   // req_addr/req_wdata document the access in flight; mem_* carry the copy
   logic unused_ok;
   assign unused_ok = ^{req_addr, req_wdata};

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a bench-owned 32x32 registered-read memory,
// a transaction-level reference model compared every cycle, and directed
// scenarios with literal expectations.
module tb_data_mem_arbiter;

   localparam int AW = 5;
   localparam int DW = 32;

   logic          CLOCK = 1'b0;
   logic          peripheral_reset;
   logic          core_req, core_we, dbg_req, dbg_we;
   logic [AW-1:0] core_addr, dbg_addr;
   logic [DW-1:0] core_wdata, dbg_wdata;
   logic          core_ack, dbg_ack, core_stall;
   logic [DW-1:0] core_rdata, dbg_rdata;
   logic          mem_en, mem_rd_en, mem_wr_en, busy;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   logic          pl_en = 1'b0;
   logic [AW-1:0] pl_addr = '0;
   logic [DW-1:0] pl_data = '0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLOCK = ~CLOCK;

   data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .CLOCK(CLOCK), .peripheral_reset(peripheral_reset),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_ack(core_ack), .core_rdata(core_rdata),
      .core_stall(core_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
      .mem_en(mem_en), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   // Single-port memory with registered read data
   logic [DW-1:0] mem_arr [32];
   always @(posedge CLOCK) begin
      if (pl_en) mem_arr[pl_addr] <= pl_data;
      if (mem_en && mem_wr_en) mem_arr[mem_addr] <= mem_wdata;
      if (mem_en && mem_rd_en) mem_rdata <= mem_arr[mem_addr];
   end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: each granted access occupies the issue cycle right
   // after the grant edge and the ack cycle after that; a new grant is
   // allowed three edges after the previous one.
   int unsigned   cyc = 0;
   int unsigned   g = 0;
   bit            txn = 0;
   bit            t_own = 0;        // 0 core, 1 debug
   bit            t_we = 0;
   logic [AW-1:0] t_addr = '0;
   logic [DW-1:0] t_wdata = '0;
   bit            m_last = 1;
   logic [DW-1:0] shadow [32];
   logic [DW-1:0] exp_crd = '0, exp_drd = '0;
   bit            model_ready = 0;

   always @(posedge CLOCK) begin
      cyc++;
      if (pl_en) shadow[pl_addr] = pl_data;
      // A write issued in the cycle just ending lands in memory even if reset hits now
      if (txn && cyc == g + 1 && t_we) shadow[t_addr] = t_wdata;
      if (peripheral_reset) begin
         txn     = 0;
         m_last  = 1;
         exp_crd = '0;
         exp_drd = '0;
      end else begin
         if (txn && cyc == g + 1 && !t_we) begin
            if (t_own) exp_drd = shadow[t_addr];
            else       exp_crd = shadow[t_addr];
         end
         if (!txn || cyc >= g + 3) begin
            txn = 0;
            if (core_req || dbg_req) begin
               t_own   = (core_req && dbg_req) ? !m_last : dbg_req;
               t_we    = t_own ? dbg_we : core_we;
               t_addr  = t_own ? dbg_addr : core_addr;
               t_wdata = t_own ? dbg_wdata : core_wdata;
               m_last  = t_own;
               g       = cyc;
               txn     = 1;
            end
         end
      end
      model_ready = 1;
   end

   // Every-cycle comparison against the model, on the falling edge
   logic m_iss, m_rsp;
   always @(negedge CLOCK) begin
      if (model_ready) begin
         m_iss = txn && (cyc == g);
         m_rsp = txn && (cyc == g + 1);
         chk("cmp_mem_en",    DW'(mem_en),    DW'(m_iss));
         chk("cmp_mem_rd_en", DW'(mem_rd_en), DW'(m_iss && !t_we));
         chk("cmp_mem_wr_en", DW'(mem_wr_en), DW'(m_iss && t_we));
         chk("cmp_mem_addr",  DW'(mem_addr),  m_iss ? DW'(t_addr) : '0);
         chk("cmp_mem_wdata", mem_wdata,      m_iss ? t_wdata : '0);
         chk("cmp_core_ack",  DW'(core_ack),  DW'(m_rsp && !t_own));
         chk("cmp_dbg_ack",   DW'(dbg_ack),   DW'(m_rsp && t_own));
         chk("cmp_core_rdata", core_rdata,    exp_crd);
         chk("cmp_dbg_rdata",  dbg_rdata,     exp_drd);
         chk("cmp_busy",      DW'(busy),      DW'(m_iss || m_rsp));
         chk("cmp_core_stall", DW'(core_stall), DW'(core_req && !(m_rsp && !t_own)));
      end
   end

   task automatic tick();
      @(posedge CLOCK);
      #2;
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      tick();
      pl_en = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      peripheral_reset = 1'b1;
      core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
      dbg_req  = 0; dbg_we  = 0; dbg_addr  = '0; dbg_wdata  = '0;
      tick();
      preload(5'd5, 32'hDEADBEEF);
      preload(5'd1, 32'h11111111);
      preload(5'd2, 32'h22222222);
      preload(5'd7, 32'hA5A5A5A5);
      preload(5'd9, 32'h99999999);

      // Reset state
      chk("rst_busy",  DW'(busy), 0);
      chk("rst_mem_en", DW'(mem_en), 0);
      chk("rst_mem_addr", DW'(mem_addr), 0);
      chk("rst_core_ack", DW'(core_ack), 0);
      chk("rst_dbg_ack", DW'(dbg_ack), 0);
      chk("rst_core_rdata", core_rdata, 0);
      chk("rst_dbg_rdata", dbg_rdata, 0);

      // 1: core load from addr 5
      peripheral_reset = 1'b0;
      core_req = 1; core_we = 0; core_addr = 5'd5;
      #1 chk("t1_stall_idle", DW'(core_stall), 1);
      tick();
      chk("t1_rd_en", DW'(mem_rd_en), 1);
      chk("t1_addr", DW'(mem_addr), 5);
      chk("t1_stall_issue", DW'(core_stall), 1);
      chk("t1_no_early_ack", DW'(core_ack), 0);
      tick();
      chk("t1_ack", DW'(core_ack), 1);
      chk("t1_rdata", core_rdata, 32'hDEADBEEF);
      chk("t1_stall_ack", DW'(core_stall), 0);
      core_req = 0;
      tick();
      chk("t1_ack_drop", DW'(core_ack), 0);
      chk("t1_rdata_hold", core_rdata, 32'hDEADBEEF);

      // 2: debug write to addr 3, then core reads it back
      dbg_req = 1; dbg_we = 1; dbg_addr = 5'd3; dbg_wdata = 32'h12345678;
      tick();
      chk("t2_wr_en", DW'(mem_wr_en), 1);
      chk("t2_addr", DW'(mem_addr), 3);
      chk("t2_wdata", mem_wdata, 32'h12345678);
      tick();
      chk("t2_wr_en_pulse", DW'(mem_wr_en), 0);
      chk("t2_dbg_ack", DW'(dbg_ack), 1);
      dbg_req = 0;
      core_req = 1; core_we = 0; core_addr = 5'd3;
      tick();
      tick();
      chk("t2_rd_en", DW'(mem_rd_en), 1);
      tick();
      chk("t2_core_ack", DW'(core_ack), 1);
      chk("t2_core_rdata", core_rdata, 32'h12345678);
      core_req = 0;
      tick();

      // 3: both requesting from reset, core wins first tie
      peripheral_reset = 1;
      core_req = 1; core_we = 0; core_addr = 5'd1;
      dbg_req  = 1; dbg_we  = 0; dbg_addr  = 5'd2;
      tick();
      peripheral_reset = 0;
      for (int i = 1; i <= 11; i++) begin
         tick();
         chk("t3_core_ack", DW'(core_ack), DW'(i == 2 || i == 8));
         chk("t3_dbg_ack",  DW'(dbg_ack),  DW'(i == 5 || i == 11));
         if (i == 2) chk("t3_core_rdata", core_rdata, 32'h11111111);
         if (i == 5) chk("t3_dbg_rdata",  dbg_rdata,  32'h22222222);
      end
      core_req = 0; dbg_req = 0;
      tick();
      chk("t3_idle", DW'(busy), 0);

      // 4: core request arrives during a debug issue; dbg_addr change ignored
      dbg_req = 1; dbg_we = 0; dbg_addr = 5'd7;
      tick();
      chk("t4_dbg_addr", DW'(mem_addr), 7);
      core_req = 1; core_we = 0; core_addr = 5'd9; dbg_addr = 5'd20;
      #1 chk("t4_addr_stable", DW'(mem_addr), 7);
      tick();
      chk("t4_dbg_ack", DW'(dbg_ack), 1);
      chk("t4_dbg_rdata", dbg_rdata, 32'hA5A5A5A5);
      chk("t4_core_wait", DW'(core_ack), 0);
      dbg_req = 0;
      tick();
      chk("t4_idle_mem_en", DW'(mem_en), 0);
      chk("t4_idle_stall", DW'(core_stall), 1);
      tick();
      chk("t4_core_addr", DW'(mem_addr), 9);
      tick();
      chk("t4_core_ack", DW'(core_ack), 1);
      chk("t4_core_rdata", core_rdata, 32'h99999999);
      core_req = 0;
      tick();

      // 5: reset during a core read issue abandons it
      core_req = 1; core_we = 0; core_addr = 5'd5;
      tick();
      chk("t5_issue", DW'(mem_rd_en), 1);
      peripheral_reset = 1;
      tick();
      chk("t5_busy", DW'(busy), 0);
      chk("t5_mem_en", DW'(mem_en), 0);
      chk("t5_mem_rd_en", DW'(mem_rd_en), 0);
      chk("t5_core_ack", DW'(core_ack), 0);
      peripheral_reset = 0;
      tick();
      chk("t5_no_stale_ack", DW'(core_ack), 0);
      chk("t5_regrant", DW'(mem_rd_en), 1);
      tick();
      chk("t5_ack", DW'(core_ack), 1);
      chk("t5_rdata", core_rdata, 32'hDEADBEEF);
      core_req = 0;
      tick();

      // 6: store to the top address with req dropped mid-access
      core_req = 1; core_we = 1; core_addr = 5'd31; core_wdata = 32'hFFFFFFFF;
      tick();
      chk("t6_wr_en", DW'(mem_wr_en), 1);
      chk("t6_addr", DW'(mem_addr), 31);
      core_req = 0;
      tick();
      chk("t6_ack", DW'(core_ack), 1);
      chk("t6_rdata_unchanged", core_rdata, 32'hDEADBEEF);
      tick();
      chk("t6_mem31", mem_arr[31], 32'hFFFFFFFF);
      core_req = 1; core_we = 0; core_addr = 5'd31;
      tick();
      tick();
      chk("t6_readback", core_rdata, 32'hFFFFFFFF);
      core_req = 0;
      tick();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
